// File: rtl/dcache_ctrl_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped data cache controller.
// Constants only; no logic, so there is no latency or backpressure here.
package dcache_ctrl_pkg;

  localparam int LINES   = 64;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

endpackage

// File: rtl/cache_tag_array.sv
// Flop-based tag store: combinational lookup, single write port and clear-all.
// Lookup is same-cycle; writes and clear land on the next edge, clear wins over write.
module cache_tag_array
  import dcache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               clear_all
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  assign lk_hit = valid[lk_idx] & (tags[lk_idx] == lk_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag bits are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller, one word per line.
// Read hit responds 1 cycle after accept; one request in flight; mem_req held until mem_req_ready.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_we,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  input  logic        cpu_flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        sram_ce,
  output logic        sram_we,
  output logic [5:0]  sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  state_t             state;
  logic [29:0]        req_line;
  logic               req_we;
  logic [31:0]        req_wdata;
  logic               flush_pend;
  logic               mreq_vld;
  logic               idle, accept, hit, clear_all, tag_wr;
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               unused_offset;

  assign unused_offset = ^cpu_req_addr[1:0];

  assign idle          = (state == IDLE);
  assign cpu_req_ready = idle & ~flush_pend & ~cpu_flush;
  assign accept        = cpu_req_valid & cpu_req_ready;
  assign clear_all     = idle & (cpu_flush | flush_pend);

  // In IDLE the lookup serves the incoming write-hit check; afterwards the latched request.
  assign lk_idx = idle ? cpu_req_addr[7:2]  : req_line[5:0];
  assign lk_tag = idle ? cpu_req_addr[31:8] : req_line[29:6];

  assign mem_req_valid = mreq_vld;
  assign mem_req_we    = req_we;
  assign mem_req_addr  = {req_line, 2'b00};
  assign mem_req_wdata = req_wdata;

  cache_tag_array u_tags (
    .clk       (clk),
    .rst       (rst),
    .lk_idx    (lk_idx),
    .lk_tag    (lk_tag),
    .lk_hit    (hit),
    .wr_en     (tag_wr),
    .wr_idx    (req_line[5:0]),
    .wr_tag    (req_line[29:6]),
    .clear_all (clear_all)
  );

  always_comb begin
    sram_ce        = 1'b0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_wdata     = '0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    tag_wr         = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sram_ce    = ~cpu_req_we | hit;
          sram_we    = cpu_req_we;
          sram_addr  = cpu_req_addr[7:2];
          sram_wdata = cpu_req_we ? cpu_req_wdata : 32'h0;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_rdata = sram_rdata;
        end
      end
      MISS_WAIT: begin
        if (mem_resp_valid) begin
          sram_ce        = 1'b1;
          sram_we        = 1'b1;
          sram_addr      = req_line[5:0];
          sram_wdata     = mem_resp_rdata;
          tag_wr         = 1'b1;
          cpu_resp_valid = 1'b1;
          cpu_resp_rdata = mem_resp_rdata;
        end
      end
      WR_WAIT: begin
        cpu_resp_valid = mem_resp_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      mreq_vld   <= 1'b0;
      req_line   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_all) begin
            flush_pend <= 1'b0;
          end else if (accept) begin
            req_line  <= cpu_req_addr[31:2];
            req_we    <= cpu_req_we;
            req_wdata <= cpu_req_wdata;
            if (cpu_req_we) begin
              state    <= WR_REQ;
              mreq_vld <= 1'b1;
            end else begin
              state <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            state    <= MISS_REQ;
            mreq_vld <= 1'b1;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            state    <= MISS_WAIT;
            mreq_vld <= 1'b0;
          end
        end
        MISS_WAIT: if (mem_resp_valid) state <= IDLE;
        WR_REQ: begin
          if (mem_req_ready) begin
            state    <= WR_WAIT;
            mreq_vld <= 1'b0;
          end
        end
        WR_WAIT: if (mem_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
      // A flush seen while busy is held until the controller is back in IDLE.
      if (!idle && cpu_flush) flush_pend <= 1'b1;
    end
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameters: none; geometry fixed at 64 lines x 32-bit words, direct-mapped, 1 word per line.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cpu_req_valid  in  1  CPU request present.
REQ-005 cpu_req_ready  out  1  controller accepts request (accept = valid & ready).
REQ-006 cpu_req_we / cpu_req_addr / cpu_req_wdata  in  1/32/32  write flag, byte address, write data.
REQ-007 cpu_resp_valid / cpu_resp_rdata  out  1/32  one-cycle completion pulse, read data (0 for writes).
REQ-008 cpu_flush  in  1  invalidate-all request pulse.
REQ-009 mem_req_valid / mem_req_ready  out/in  1/1  next-level memory handshake.
REQ-010 mem_req_we / mem_req_addr / mem_req_wdata  out  1/32/32  memory op, word-aligned address, data.
REQ-011 mem_resp_valid / mem_resp_rdata  in  1/32  memory completion (read data or write ack).
REQ-012 sram_ce / sram_we / sram_addr / sram_wdata  out  1/1/6/32  data-array access; sram_ce=1 selects the array this cycle.
REQ-013 sram_rdata  in  32  data-array read data, valid the cycle after a read access.

Function
REQ-014 Address split: offset [1:0] ignored, index [7:2], tag [31:8]; accesses are full-word only.
REQ-015 Tag store: 64 entries of {valid, 24-bit tag} in flops.
REQ-016 FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT.
REQ-017 cpu_req_ready=1 only in IDLE with no pending flush.
REQ-018 Read accept (IDLE): sram_ce=1, sram_we=0, sram_addr=index same cycle; latch address; go to LOOKUP.
REQ-019 LOOKUP hit (valid & tag match): cpu_resp_valid=1, rdata=sram_rdata; go to IDLE; hit latency 1 cycle after accept.
REQ-020 LOOKUP miss: go to MISS_REQ; mem_req_valid=1, we=0, addr={addr[31:2],2'b0}; on mem_req_ready go to MISS_WAIT.
REQ-021 MISS_WAIT on mem_resp_valid: same cycle write SRAM (ce=1, we=1, wdata=mem_resp_rdata), set valid/tag, cpu_resp_valid=1 with rdata=mem_resp_rdata; go to IDLE.
REQ-022 Write accept (IDLE): on tag hit, SRAM write of cpu_req_wdata in the accept cycle; on miss, SRAM and tags untouched (no-write-allocate); go to WR_REQ.
REQ-023 WR_REQ: mem_req_valid=1, we=1, write-through of wdata; on ready go to WR_WAIT; on mem_resp_valid, cpu_resp_valid=1, rdata=0; go to IDLE.
REQ-024 mem_req_* held stable while mem_req_valid & !mem_req_ready; mem_req_valid deasserts the cycle after handshake.
REQ-025 mem_resp_valid outside MISS_WAIT/WR_WAIT is ignored.
REQ-026 cpu_flush in IDLE clears all valid bits next edge, no request accepted that cycle; if busy, flush is latched and applied on return to IDLE before the next accept.
REQ-027 At most one outstanding CPU request and one outstanding memory request.
REQ-028 sram_ce=0 in every cycle not listed in REQ-018/021/022.

Reset
REQ-029 rst asserted: FSM=IDLE, all valid bits=0, pending flush=0, cpu_resp_valid=0, mem_req_valid=0, sram_ce=0, sram_we=0, cpu_req_ready=1 after release.
REQ-030 Reset mid-transaction abandons it; a later mem_resp_valid is ignored per REQ-025.

Structure
REQ-031 Shared cache package holds LINES=64, INDEX_W=6, TAG_W=24 and the FSM state encoding.
REQ-032 Tag store is one sub-module, cache_tag_array (lookup port, write port, clear-all).

Verification
REQ-033 Read 0x0000_0104 after reset -> miss; mem_req addr 0x104; mem returns 0xDEADBEEF -> cpu_resp rdata 0xDEADBEEF same cycle; SRAM written at index 1.
REQ-034 Repeat read 0x104 -> hit; cpu_resp 1 cycle after accept, no mem_req.
REQ-035 Read 0x0000_0204 (same index, tag 0x02) -> miss and refill; then read 0x104 -> miss.
REQ-036 Write 0x104 = 0x12345678 on hit -> SRAM written at accept; mem_req we=1 held 3 cycles with ready=0; ack -> resp rdata 0; read 0x104 hits 0x12345678.
REQ-037 Write miss 0x0000_0308 -> no SRAM write, valid[2] unchanged; subsequent read 0x308 misses.
REQ-038 cpu_flush during MISS_WAIT -> refill completes, flush applied in IDLE, next read of refilled address misses; rst during MISS_REQ -> mem_req_valid=0 immediately, late mem_resp_valid ignored.
